// File: rtl/rf_wport_sched.sv
// rf_wport_sched: arbitrates the single regfile write port between pipeline
// writeback and a 2-deep long-op result FIFO, with a busy-register scoreboard.
module rf_wport_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   input  logic        lop_issue,
   input  logic [4:0]  lop_rd,
   input  logic        lop_valid,
   input  logic [4:0]  lop_waddr,
   input  logic [31:0] lop_wdata,
   output logic        lop_ready,
   input  logic        id_re1,
   input  logic [4:0]  id_raddr1,
   input  logic        id_re2,
   input  logic [4:0]  id_raddr2,
   input  logic        id_we,
   input  logic [4:0]  id_waddr,
   output logic        id_stall,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      STARVE = 2'd2
   } state_e;

   logic [1:0][4:0]  addr_q, addr_d;
   logic [1:0][31:0] data_q, data_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [1:0]       count_q, count_d;
   logic [2:0]       age_q, age_d;
   logic [31:1]      busy_q, busy_d;
   state_e           state_q, state_d;

   logic             push;
   logic             pop;
   logic [4:0]       head_addr;
   logic [31:0]      head_data;
   logic [31:1]      clr_mask;
   logic [31:1]      set_mask;
   logic [31:0]      bp;

   // FIFO head and handshake qualifiers; nothing moves while in reset
   always_comb begin
      head_addr = addr_q[rptr_q];
      head_data = data_q[rptr_q];
      lop_ready = !rst && (count_q != 2'd2);
      push      = lop_valid && lop_ready;
      pop       = !rst && !wb_we && (count_q != 2'd0);
   end

   // FIFO storage, pointers and occupancy
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         addr_d[wptr_q] = lop_waddr;
         data_d[wptr_q] = lop_wdata;
         wptr_d         = !wptr_q;
      end
      if (pop) begin
         rptr_d = !rptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Write port grant: writeback has priority, FIFO head drains otherwise
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (!rst && wb_we) begin
         rf_we    = 1'b1;
         rf_waddr = wb_waddr;
         rf_wdata = wb_wdata;
      end else if (pop) begin
         rf_we    = (head_addr != 5'd0);
         rf_waddr = head_addr;
         rf_wdata = head_data;
      end
   end

   // Scoreboard: clear on pop of the matching head, set on issue (set wins)
   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      for (int i = 1; i < 32; i++) begin
         clr_mask[i] = pop && (head_addr == 5'(i));
         set_mask[i] = lop_issue && (lop_rd == 5'(i));
      end
      busy_d = (busy_q & ~clr_mask) | set_mask;
      bp     = {busy_q & ~clr_mask, 1'b0};
   end

   // Age of the head entry, saturating at 7
   always_comb begin
      if (pop || count_q == 2'd0) begin
         age_d = 3'd0;
      end else if (age_q == 3'd7) begin
         age_d = age_q;
      end else begin
         age_d = age_q + 3'd1;
      end
   end

   // Next-state logic; an empty FIFO always lands in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (push) state_d = PEND;
         PEND:    if (age_d == 3'd7) state_d = STARVE;
         STARVE:  if (pop) state_d = PEND;
         default: state_d = IDLE;
      endcase
      if (count_d == 2'd0) begin
         state_d = IDLE;
      end
   end

   // Stall request: hazards on pending long-op results, full FIFO, starvation
   always_comb begin
      id_stall = 1'b0;
      if (!rst) begin
         id_stall = (id_re1 && bp[id_raddr1])
                 || (id_re2 && bp[id_raddr2])
                 || (id_we  && bp[id_waddr])
                 || (count_q == 2'd2)
                 || (state_q == STARVE);
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
         age_q   <= 3'd0;
         busy_q  <= '0;
         state_q <= IDLE;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         age_q   <= age_d;
         busy_q  <= busy_d;
         state_q <= state_d;
      end
   end

endmodule
